// File: rtl/pid_pkg.sv
// Shared types and internal widths for the time-multiplexed multi-axis PID controller.
package pid_pkg;

    localparam int EW   = 32;   // error width
    localparam int AW   = 40;   // integrator accumulator width
    localparam int SUMW = 48;   // P+I+D sum width
    localparam int MAW  = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GYR,
        ST_P,
        ST_I,
        ST_D,
        ST_SUM
    } state_t;

    // Encoded as a 2-bit signed value: +1, -1 or 0.
    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_POS  = 2'b01,
        SAT_NEG  = 2'b11
    } sat_t;

endpackage

// File: rtl/pid_sat.sv
// Combinational symmetric signed clip of x to +/-LIM.
module pid_sat
    import pid_pkg::*;
#(
    parameter int     W   = 48,
    parameter longint LIM = 4095
) (
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    localparam logic signed [W-1:0] HI = W'(LIM);
    localparam logic signed [W-1:0] LO = -HI;

    always_comb begin
        y = x;
        if (x > HI) begin
            y = HI;
        end else if (x < LO) begin
            y = LO;
        end
    end

endmodule

// File: rtl/pid_multi_axis.sv
// PID rate controller for NAXES axes sharing one signed multiplier; each axis takes
// GYR, P, I, D, SUM cycles, then out_valid pulses one cycle after the last SUM.
module pid_multi_axis
    import pid_pkg::*;
#(
    parameter int NAXES        = 3,
    parameter int GW           = 16,
    parameter int SW           = 12,
    parameter int OW           = 13,
    parameter int KW           = 16,
    parameter int GAIN_FRAC    = 8,
    parameter int FRAC         = 8,
    parameter int GYRO_FS      = 1000,
    parameter int STICK_CENTER = 500,
    parameter int DEADBAND     = 4,
    parameter int DEPTH        = 8,
    parameter int ITERM_MAX    = 1 << 20,
    parameter int OUT_MAX      = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_ready,
    input  logic [NAXES*GW-1:0]   gyro,
    input  logic [NAXES*SW-1:0]   stick,
    input  logic [NAXES*KW-1:0]   kp,
    input  logic [NAXES*KW-1:0]   ki,
    input  logic [NAXES*KW-1:0]   kd,
    input  logic                  arm,
    output logic [NAXES*OW-1:0]   power,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int AXW  = (NAXES > 1) ? $clog2(NAXES) : 1;
    localparam int PTRW = $clog2(DEPTH);
    localparam int MBW  = KW + 1;
    localparam int PW   = MAW + MBW;
    localparam int GSH  = GW - 1 - FRAC;
    localparam int OSH  = FRAC + GAIN_FRAC;
    localparam logic signed [EW-1:0] DB = EW'(DEADBAND);

    state_t              state;
    logic [AXW-1:0]      axis;
    logic [PTRW-1:0]     ptr;
    logic                fin;
    logic                arm_r;
    logic                accept;

    logic [NAXES*GW-1:0] gyro_r;
    logic [NAXES*SW-1:0] stick_r;
    logic [NAXES*KW-1:0] kp_r, ki_r, kd_r;

    logic signed [EW-1:0]   err;
    logic signed [AW-1:0]   acc  [NAXES];
    sat_t                   sat  [NAXES];
    logic signed [EW-1:0]   hist [NAXES][DEPTH];
    logic signed [SUMW-1:0] p_t, i_t, d_t;

    logic signed [GW-1:0]   gyro_a;
    logic [SW-1:0]          stick_a;
    logic [KW-1:0]          kp_a, ki_a, kd_a;
    logic signed [EW-1:0]   stick_d, sp, hist_rd;
    logic signed [EW:0]     diff;
    logic                   freeze;
    logic signed [AW-1:0]   acc_sum, acc_clip, acc_new;
    logic signed [MAW-1:0]  mul_a;
    logic signed [MBW-1:0]  mul_b;
    logic signed [PW-1:0]   prod;
    logic signed [SUMW-1:0] sum_all, sum_s, sum_clip;
    sat_t                   sum_flag;

    assign gyro_a  = gyro_r[axis*GW +: GW];
    assign stick_a = stick_r[axis*SW +: SW];
    assign kp_a    = kp_r[axis*KW +: KW];
    assign ki_a    = ki_r[axis*KW +: KW];
    assign kd_a    = kd_r[axis*KW +: KW];
    assign hist_rd = hist[axis][ptr];

    assign accept  = (state == ST_IDLE) && !fin && !out_valid;

    always_comb begin
        stick_d = $signed({{(EW-SW){1'b0}}, stick_a}) - EW'(STICK_CENTER);
        sp      = ((stick_d <= DB) && (stick_d >= -DB)) ? '0 : (stick_d <<< FRAC);
        diff    = (EW+1)'(err) - (EW+1)'(hist_rd);
    end

    // Anti-windup: hold the integrator while pushing further into the saturated direction.
    always_comb begin
        freeze  = ((sat[axis] == SAT_POS) && (err > 0)) ||
                  ((sat[axis] == SAT_NEG) && (err < 0));
        acc_sum = freeze ? acc[axis] : acc[axis] + AW'(err);
        acc_new = arm_r ? acc_clip : '0;
    end

    pid_sat #(
        .W   (AW),
        .LIM (ITERM_MAX)
    ) u_iclamp (
        .x (acc_sum),
        .y (acc_clip)
    );

    // Single shared multiplier; operands selected by the current phase.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_GYR: begin
                mul_a = MAW'(gyro_a);
                mul_b = MBW'(GYRO_FS);
            end
            ST_P: begin
                mul_a = MAW'(err);
                mul_b = $signed({1'b0, kp_a});
            end
            ST_I: begin
                mul_a = MAW'(acc_new);
                mul_b = $signed({1'b0, ki_a});
            end
            ST_D: begin
                mul_a = MAW'(diff);
                mul_b = $signed({1'b0, kd_a});
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    assign prod = mul_a * mul_b;

    always_comb begin
        sum_all  = p_t + i_t + d_t;
        sum_s    = sum_all >>> OSH;
        sum_flag = (sum_s == sum_clip) ? SAT_NONE :
                   (sum_s[SUMW-1] ? SAT_NEG : SAT_POS);
    end

    pid_sat #(
        .W   (SUMW),
        .LIM (OUT_MAX)
    ) u_oclip (
        .x (sum_s),
        .y (sum_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            axis      <= '0;
            ptr       <= '0;
            fin       <= 1'b0;
            arm_r     <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            power     <= '0;
            gyro_r    <= '0;
            stick_r   <= '0;
            kp_r      <= '0;
            ki_r      <= '0;
            kd_r      <= '0;
            err       <= '0;
            p_t       <= '0;
            i_t       <= '0;
            d_t       <= '0;
            acc       <= '{default: '0};
            sat       <= '{default: SAT_NONE};
            hist      <= '{default: '{default: '0}};
        end else begin
            out_valid <= 1'b0;
            if (data_ready && !accept) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (fin) begin
                        fin       <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end else if (data_ready && !out_valid) begin
                        gyro_r  <= gyro;
                        stick_r <= stick;
                        kp_r    <= kp;
                        ki_r    <= ki;
                        kd_r    <= kd;
                        arm_r   <= arm;
                        axis    <= '0;
                        busy    <= 1'b1;
                        state   <= ST_GYR;
                    end
                end
                ST_GYR: begin
                    err   <= sp - EW'(prod >>> GSH);
                    state <= ST_P;
                end
                ST_P: begin
                    p_t   <= SUMW'(prod);
                    state <= ST_I;
                end
                ST_I: begin
                    acc[axis] <= acc_new;
                    i_t       <= SUMW'(prod);
                    state     <= ST_D;
                end
                ST_D: begin
                    d_t             <= SUMW'(prod);
                    hist[axis][ptr] <= err;
                    state           <= ST_SUM;
                end
                ST_SUM: begin
                    power[axis*OW +: OW] <= arm_r ? sum_clip[OW-1:0] : '0;
                    sat[axis]            <= arm_r ? sum_flag : SAT_NONE;
                    if (axis == AXW'(NAXES - 1)) begin
                        axis  <= '0;
                        ptr   <= ptr + 1'b1;
                        fin   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        axis  <= axis + 1'b1;
                        state <= ST_GYR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_multi_axis.sv
// Scoreboard bench for pid_multi_axis: a behavioural model queues expected power per sample.
module tb_pid_multi_axis;

    localparam int NAX = 3;
    localparam int GW  = 16;
    localparam int SW  = 12;
    localparam int OW  = 13;
    localparam int KW  = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               data_ready;
    logic               arm;
    logic [NAX*GW-1:0]  gyro;
    logic [NAX*SW-1:0]  stick;
    logic [NAX*KW-1:0]  kp, ki, kd;
    logic [NAX*OW-1:0]  power;
    logic               out_valid, busy, overrun;

    pid_multi_axis dut (
        .clk        (clk),
        .rst        (rst),
        .data_ready (data_ready),
        .gyro       (gyro),
        .stick      (stick),
        .kp         (kp),
        .ki         (ki),
        .kd         (kd),
        .arm        (arm),
        .power      (power),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int nv;

    int gv [NAX];
    int sv [NAX];
    int kpv[NAX];
    int kiv[NAX];
    int kdv[NAX];

    longint m_acc [NAX];
    int     m_sat [NAX];
    longint m_hist[NAX][8];
    int     m_ptr;

    logic [NAX*OW-1:0] exp_q[$];
    logic [NAX*OW-1:0] mon_e;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint pwr(input int a);
        return longint'($signed(power[a*OW +: OW]));
    endfunction

    task automatic model_clear();
        for (int a = 0; a < NAX; a++) begin
            m_acc[a] = 0;
            m_sat[a] = 0;
            for (int k = 0; k < 8; k++) m_hist[a][k] = 0;
        end
        m_ptr = 0;
        exp_q.delete();
    endtask

    task automatic model_step(output logic [NAX*OW-1:0] ev);
        longint g, sd, sp, e, pp, ip, dp, s, o;
        ev = '0;
        for (int a = 0; a < NAX; a++) begin
            g  = (longint'(gv[a]) * 1000) >>> 7;
            sd = longint'(sv[a]) - 500;
            sp = (sd >= -4 && sd <= 4) ? 0 : sd * 256;
            e  = sp - g;
            pp = e * kpv[a];
            if (arm) begin
                if (!((m_sat[a] > 0 && e > 0) || (m_sat[a] < 0 && e < 0))) m_acc[a] += e;
                if (m_acc[a] > 1048576) m_acc[a] = 1048576;
                else if (m_acc[a] < -1048576) m_acc[a] = -1048576;
            end else begin
                m_acc[a] = 0;
            end
            ip = m_acc[a] * kiv[a];
            dp = (e - m_hist[a][m_ptr]) * kdv[a];
            m_hist[a][m_ptr] = e;
            s = (pp + ip + dp) >>> 16;
            o = s;
            m_sat[a] = 0;
            if (s > 4095) begin
                o = 4095;
                m_sat[a] = 1;
            end else if (s < -4095) begin
                o = -4095;
                m_sat[a] = -1;
            end
            if (!arm) begin
                o = 0;
                m_sat[a] = 0;
            end
            ev[a*OW +: OW] = OW'(o);
        end
        m_ptr = (m_ptr + 1) % 8;
    endtask

    task automatic set_axis(input int a, input int g, input int s, input int p, input int i, input int d);
        gv[a] = g; sv[a] = s; kpv[a] = p; kiv[a] = i; kdv[a] = d;
    endtask

    task automatic set_idle_axes();
        for (int a = 0; a < NAX; a++) set_axis(a, 0, 500, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic accept_sample();
        logic [NAX*OW-1:0] e;
        @(negedge clk);
        for (int a = 0; a < NAX; a++) begin
            gyro[a*GW +: GW]  = GW'(gv[a]);
            stick[a*SW +: SW] = SW'(sv[a]);
            kp[a*KW +: KW]    = KW'(kpv[a]);
            ki[a*KW +: KW]    = KW'(kiv[a]);
            kd[a*KW +: KW]    = KW'(kdv[a]);
        end
        data_ready = 1'b1;
        @(posedge clk);
        model_step(e);
        exp_q.push_back(e);
        #1 data_ready = 1'b0;
        check_eq("busy_after_accept", busy, 1);
    endtask

    task automatic wait_valid(input int start);
        int n = start;
        bit seen = 1'b0;
        while (!seen && n < start + 40) begin
            @(posedge clk);
            n++;
            #1 seen = out_valid;
        end
        if (seen) check_eq("latency", n, 16);
        else check_eq("valid_timeout", out_valid, 1);
    endtask

    task automatic send();
        accept_sample();
        wait_valid(0);
        check_eq("busy_at_valid", busy, 0);
        @(posedge clk);
        #1 check_eq("valid_pulse", out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                for (int a = 0; a < NAX; a++)
                    check_eq($sformatf("power%0d", a), pwr(a),
                             longint'($signed(mon_e[a*OW +: OW])));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; data_ready = 1'b0; arm = 1'b1;
        gyro = '0; stick = '0; kp = '0; ki = '0; kd = '0;
        set_idle_axes();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        check_eq("rst_power", power, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);

        // Centred sticks, still gyro: zero output everywhere.
        for (int a = 0; a < NAX; a++) set_axis(a, 0, 500, 256, 0, 0);
        send();
        check_eq("t1_axis1", pwr(1), 0);

        // Derivative window: history reads zero until DEPTH samples have been stored.
        do_reset();
        set_idle_axes();
        set_axis(0, 0, 600, 256, 0, 256);
        for (int k = 1; k <= 9; k++) begin
            send();
            if (k == 1) check_eq("t2_first", pwr(0), 200);
            if (k == 9) check_eq("t2_window_full", pwr(0), 100);
        end

        // Gyro path and deadband edges.
        do_reset();
        set_idle_axes();
        set_axis(0, -3277, 500, 256, 0, 0);
        send();
        check_eq("t3_gyro", pwr(0), 100);
        sv[0] = 502; send();
        check_eq("t3_db_502", pwr(0), 100);
        sv[0] = 496; send();
        check_eq("t3_db_496", pwr(0), 100);
        sv[0] = 505; send();
        check_eq("t3_db_505", pwr(0), 105);

        // Output saturation in both directions.
        do_reset();
        set_idle_axes();
        set_axis(0, 0, 4000, 512, 0, 0);
        send();
        check_eq("t4_pos_sat", pwr(0), 4095);
        set_axis(0, 32767, 500, 2048, 0, 0);
        send();
        check_eq("t4_neg_sat", pwr(0), -4095);

        // Saturation freezes the integrator: acc stays at 896000 instead of clamping.
        do_reset();
        set_idle_axes();
        set_axis(0, 0, 4000, 512, 64, 0);
        send();
        send();
        set_axis(0, 0, 500, 0, 64, 0);
        send();
        check_eq("t4_freeze", pwr(0), 875);

        // Integrator clamp at ITERM_MAX with back-to-back samples.
        do_reset();
        set_idle_axes();
        set_axis(0, 0, 600, 0, 64, 0);
        for (int k = 0; k < 45; k++) send();
        check_eq("t5_clamp", pwr(0), 1024);
        check_eq("t5_no_overrun", overrun, 0);

        // Disarmed: power zero and integrator cleared.
        do_reset();
        set_idle_axes();
        set_axis(0, 0, 600, 256, 64, 0);
        arm = 1'b0;
        send();
        check_eq("arm0_power", pwr(0), 0);
        arm = 1'b1;
        send();
        check_eq("arm1_power", pwr(0), 125);

        // Overrun: data_ready while busy and in the out_valid cycle is dropped.
        do_reset();
        set_idle_axes();
        set_axis(0, 0, 600, 256, 0, 0);
        send();
        accept_sample();
        repeat (4) @(posedge clk);
        #1 data_ready = 1'b1;
        @(posedge clk);
        #1 data_ready = 1'b0;
        check_eq("t6_overrun_set", overrun, 1);
        wait_valid(5);
        data_ready = 1'b1;
        @(posedge clk);
        #1 data_ready = 1'b0;
        nv = n_valid;
        repeat (20) @(posedge clk);
        #1 check_eq("t6_dropped", n_valid, nv);
        check_eq("t6_overrun_sticky", overrun, 1);
        send();
        check_eq("t6_after_drop", pwr(0), 100);
        check_eq("t6_overrun_held", overrun, 1);

        // Reset in the middle of a computation aborts it.
        accept_sample();
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        check_eq("t6_rst_power", power, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_overrun", overrun, 0);
        check_eq("t6_rst_valid", out_valid, 0);
        nv = n_valid;
        repeat (25) @(posedge clk);
        #1 check_eq("t6_no_valid", n_valid, nv);

        // Random samples against the model.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            for (int a = 0; a < NAX; a++)
                set_axis(a, int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 4095)),
                         int'($urandom_range(0, 1023)),
                         int'($urandom_range(0, 63)),
                         int'($urandom_range(0, 255)));
            arm = ($urandom_range(0, 7) != 0);
            send();
        end

        repeat (4) @(posedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
